// File: rtl/or1200_checker_ctrl.sv
// Checker-health supervisor: counts consecutive failing samples, raises a
// halting alarm, and locks the CPU out after too many acknowledged alarms.
module or1200_checker_ctrl #(
    parameter logic [3:0] STRIKE_MAX = 4'd2,
    parameter logic [3:0] LOCK_MAX   = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sample_hold,
    input  logic       sr_ok,
    input  logic       pipeline_ok,
    input  logic       mmus_ok,
    input  logic [2:0] secure_supv,
    input  logic       alarm_ack,
    input  logic       clear_req,
    output logic       halt_req,
    output logic       alarm_irq,
    output logic [2:0] fault_code,
    output logic [3:0] alarm_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MONITOR = 3'd1,
        SUSPECT = 3'd2,
        ALARM   = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] strike_q, strike_d;
    logic [2:0] fault_q, fault_d;
    logic [3:0] count_q, count_d;

    logic       fail;
    logic [2:0] fvec;
    logic       sample;
    logic       supv_ok;
    logic [3:0] strike_inc;
    logic [3:0] count_inc;

    assign fail       = ~(sr_ok & pipeline_ok & mmus_ok);
    assign fvec       = {~sr_ok, ~pipeline_ok, ~mmus_ok};
    assign sample     = enable & ~sample_hold;
    assign supv_ok    = ~^secure_supv;
    assign strike_inc = strike_q + 4'd1;
    assign count_inc  = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        strike_d = strike_q;
        fault_d  = fault_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                strike_d = 4'd0;
                fault_d  = 3'd0;
                if (enable) state_d = MONITOR;
            end
            MONITOR: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sample && fail) begin
                    fault_d  = fault_q | fvec;
                    strike_d = 4'd1;
                    state_d  = (STRIKE_MAX == 4'd1) ? ALARM : SUSPECT;
                end
            end
            SUSPECT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sample && fail) begin
                    strike_d = strike_inc;
                    fault_d  = fault_q | fvec;
                    if (strike_inc == STRIKE_MAX) state_d = ALARM;
                end else if (sample) begin
                    state_d  = MONITOR;
                    strike_d = 4'd0;
                    fault_d  = 3'd0;
                end
            end
            ALARM: begin
                if (alarm_ack) begin
                    count_d = count_inc;
                    if (count_inc >= LOCK_MAX) begin
                        state_d = LOCKOUT;
                    end else begin
                        state_d  = MONITOR;
                        strike_d = 4'd0;
                        fault_d  = 3'd0;
                    end
                end
            end
            LOCKOUT: begin
                if (clear_req && supv_ok) begin
                    state_d  = MONITOR;
                    count_d  = 4'd0;
                    strike_d = 4'd0;
                    fault_d  = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            strike_q  <= 4'd0;
            fault_q   <= 3'd0;
            count_q   <= 4'd0;
            halt_req  <= 1'b0;
            alarm_irq <= 1'b0;
        end else begin
            state_q   <= state_d;
            strike_q  <= strike_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
            // Decoded from the next state so the flags line up with state.
            halt_req  <= (state_d == ALARM) || (state_d == LOCKOUT);
            alarm_irq <= (state_d == ALARM);
        end
    end

    assign state       = state_q;
    assign fault_code  = fault_q;
    assign alarm_count = count_q;

endmodule

// File: tb/tb_or1200_checker_ctrl.sv
// Self-checking bench for or1200_checker_ctrl: directed sequences followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_or1200_checker_ctrl;

    localparam int SM = 2;
    localparam int LM = 4;

    logic       clk;
    logic       rst;
    logic       enable, sample_hold;
    logic       sr_ok, pipeline_ok, mmus_ok;
    logic [2:0] secure_supv;
    logic       alarm_ack, clear_req;
    logic       halt_req, alarm_irq;
    logic [2:0] fault_code;
    logic [3:0] alarm_count;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: abstract state number, strike, sticky faults, alarm tally.
    int         m_state, m_strike, m_count;
    logic [2:0] m_fault;

    or1200_checker_ctrl #(.STRIKE_MAX(4'd2), .LOCK_MAX(4'd4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_hold(sample_hold),
        .sr_ok(sr_ok), .pipeline_ok(pipeline_ok), .mmus_ok(mmus_ok),
        .secure_supv(secure_supv), .alarm_ack(alarm_ack), .clear_req(clear_req),
        .halt_req(halt_req), .alarm_irq(alarm_irq), .fault_code(fault_code),
        .alarm_count(alarm_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_strike = 0; m_count = 0; m_fault = 3'd0;
    endtask

    task automatic model_step();
        bit         fail, smp, sv;
        logic [2:0] fv;
        fail = !(sr_ok && pipeline_ok && mmus_ok);
        fv   = {!sr_ok, !pipeline_ok, !mmus_ok};
        smp  = enable && !sample_hold;
        sv   = ((secure_supv[0] + secure_supv[1] + secure_supv[2]) % 2) == 0;
        case (m_state)
            0: begin
                m_strike = 0; m_fault = 3'd0;
                if (enable) m_state = 1;
            end
            1: if (!enable) m_state = 0;
               else if (smp && fail) begin
                   m_fault |= fv; m_strike = 1;
                   m_state = (SM == 1) ? 3 : 2;
               end
            2: if (!enable) m_state = 0;
               else if (smp && fail) begin
                   m_strike++; m_fault |= fv;
                   if (m_strike == SM) m_state = 3;
               end else if (smp) begin
                   m_state = 1; m_strike = 0; m_fault = 3'd0;
               end
            3: if (alarm_ack) begin
                   m_count = (m_count + 1 > 15) ? 15 : m_count + 1;
                   if (m_count >= LM) m_state = 4;
                   else begin m_state = 1; m_strike = 0; m_fault = 3'd0; end
               end
            4: if (clear_req && sv) begin
                   m_state = 1; m_count = 0; m_strike = 0; m_fault = 3'd0;
               end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_model();
        check("state", 8'(state), 8'(m_state));
        check("halt_req", 8'(halt_req), 8'((m_state == 3) || (m_state == 4)));
        check("alarm_irq", 8'(alarm_irq), 8'(m_state == 3));
        check("fault_code", 8'(fault_code), 8'(m_fault));
        check("alarm_count", 8'(alarm_count), 8'(m_count));
    endtask

    // Advance one clock, update the model, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic healthy();
        sr_ok = 1'b1; pipeline_ok = 1'b1; mmus_ok = 1'b1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; sample_hold = 1'b0; healthy();
        secure_supv = 3'd0; alarm_ack = 1'b0; clear_req = 1'b0;
        model_reset();
        #12;
        check("rst_state", 8'(state), 8'd0);
        check("rst_halt", 8'(halt_req), 8'd0);
        check("rst_irq", 8'(alarm_irq), 8'd0);
        check("rst_fault", 8'(fault_code), 8'd0);
        check("rst_count", 8'(alarm_count), 8'd0);
        rst = 1'b1;

        // Two failing sr samples raise an alarm.
        enable = 1'b1;
        tick(); check("seq1_monitor", 8'(state), 8'd1);
        sr_ok = 1'b0;
        tick(); check("seq1_suspect", 8'(state), 8'd2);
        tick(); check("seq1_alarm", 8'(state), 8'd3);
        check("seq1_halt", 8'(halt_req), 8'd1);
        check("seq1_irq", 8'(alarm_irq), 8'd1);
        check("seq1_fault", 8'(fault_code), 8'b100);
        healthy(); enable = 1'b0;
        tick(); check("alarm_ignores_enable", 8'(state), 8'd3);
        enable = 1'b1; alarm_ack = 1'b1;
        tick(); check("ack1_count", 8'(alarm_count), 8'd1);
        check("ack1_state", 8'(state), 8'd1);
        check("ack1_irq", 8'(alarm_irq), 8'd0);
        alarm_ack = 1'b0;

        // A single pipeline glitch recovers without halting.
        pipeline_ok = 1'b0;
        tick(); check("seq2_suspect", 8'(state), 8'd2);
        check("seq2_halt_a", 8'(halt_req), 8'd0);
        healthy();
        tick(); check("seq2_monitor", 8'(state), 8'd1);
        check("seq2_fault", 8'(fault_code), 8'd0);
        check("seq2_halt_b", 8'(halt_req), 8'd0);

        // Frozen samples hold SUSPECT; release trips the alarm.
        mmus_ok = 1'b0;
        tick(); check("seq3_suspect", 8'(state), 8'd2);
        sample_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check("seq3_hold", 8'(state), 8'd2);
        end
        sample_hold = 1'b0;
        tick(); check("seq3_alarm", 8'(state), 8'd3);
        check("seq3_fault", 8'(fault_code), 8'b001);
        healthy(); alarm_ack = 1'b1;
        tick(); check("ack2_count", 8'(alarm_count), 8'd2);
        alarm_ack = 1'b0;

        // Two more alarms reach the lockout threshold.
        for (int a = 0; a < 2; a++) begin
            sr_ok = 1'b0;
            tick(); tick(); check("seq4_alarm", 8'(state), 8'd3);
            alarm_ack = 1'b1;
            tick();
            alarm_ack = 1'b0; healthy();
        end
        check("seq4_count", 8'(alarm_count), 8'd4);
        check("seq4_lockout", 8'(state), 8'd4);
        check("seq4_halt", 8'(halt_req), 8'd1);
        check("seq4_irq", 8'(alarm_irq), 8'd0);
        check("seq4_fault_kept", 8'(fault_code), 8'b100);
        clear_req = 1'b1; secure_supv = 3'b001;
        tick(); check("odd_clear_state", 8'(state), 8'd4);
        check("odd_clear_count", 8'(alarm_count), 8'd4);
        clear_req = 1'b0; alarm_ack = 1'b1;
        tick(); check("ack_in_lockout", 8'(alarm_count), 8'd4);
        alarm_ack = 1'b0;

        // Supervisor clear leaves lockout.
        clear_req = 1'b1; secure_supv = 3'b011;
        tick(); check("seq5_state", 8'(state), 8'd1);
        check("seq5_count", 8'(alarm_count), 8'd0);
        check("seq5_fault", 8'(fault_code), 8'd0);
        check("seq5_halt", 8'(halt_req), 8'd0);
        clear_req = 1'b0;

        // Asynchronous reset in the middle of an alarm.
        sr_ok = 1'b0;
        tick(); tick(); check("seq6_alarm", 8'(state), 8'd3);
        #2 rst = 1'b0;
        #1;
        check("seq6_halt", 8'(halt_req), 8'd0);
        check("seq6_irq", 8'(alarm_irq), 8'd0);
        check("seq6_state", 8'(state), 8'd0);
        model_reset();
        healthy();
        #2 rst = 1'b1;
        tick(); check("seq6_restart", 8'(state), 8'd1);
        check("seq6_no_irq", 8'(alarm_irq), 8'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            enable      = ($urandom_range(0, 19) != 0);
            sample_hold = ($urandom_range(0, 4) == 0);
            sr_ok       = ($urandom_range(0, 6) != 0);
            pipeline_ok = ($urandom_range(0, 6) != 0);
            mmus_ok     = ($urandom_range(0, 6) != 0);
            secure_supv = 3'($urandom_range(0, 7));
            alarm_ack   = ($urandom_range(0, 3) == 0);
            clear_req   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/or1200_checker_ctrl.md
OR1200_CHECKER_CTRL -- requirements
Module: or1200_checker_ctrl

Interface
REQ-001 The block SHALL have parameter STRIKE_MAX, default 4'd2, meaning consecutive failing samples (1..15) needed to raise an alarm.
REQ-002 The block SHALL have parameter LOCK_MAX, default 4'd4, meaning acknowledged alarms (1..15) after which the block locks out.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock for all state.
REQ-004 The block SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1, meaning monitoring enable.
REQ-006 The block SHALL have port sample_hold, input, 1, meaning pipeline frozen; when 1, no sample is taken that cycle.
REQ-007 The block SHALL have ports sr_ok, pipeline_ok and mmus_ok, each input, 1, meaning checker health flags (1 = healthy).
REQ-008 The block SHALL have port secure_supv, input, 3, meaning the supervisor token; even parity means supervisor.
REQ-009 The block SHALL have port alarm_ack, input, 1, meaning the alarm handler acknowledge.
REQ-010 The block SHALL have port clear_req, input, 1, meaning the lockout clear request.
REQ-011 The block SHALL have port halt_req, output, 1, meaning CPU halt request.
REQ-012 The block SHALL have port alarm_irq, output, 1, meaning interrupt to the alarm handler.
REQ-013 The block SHALL have port fault_code, output, 3, meaning sticky failure bits {sr, pipeline, mmu}.
REQ-014 The block SHALL have port alarm_count, output, 4, meaning the acknowledged-alarm counter.
REQ-015 The block SHALL have port state, output, 3, meaning the encoded FSM state.

Function
REQ-016 Definitions SHALL be:
- fail = ~(sr_ok & pipeline_ok & mmus_ok)
- fvec = {~sr_ok, ~pipeline_ok, ~mmus_ok}
- sample = enable & ~sample_hold
- supv_ok = ~^secure_supv
REQ-017 The FSM states SHALL be encoded on state as IDLE=0, MONITOR=1, SUSPECT=2, ALARM=3, LOCKOUT=4; all other codes SHALL go to IDLE on the next clock.
REQ-018 IDLE SHALL go to MONITOR when enable=1; strike is 0 and fault_code is cleared in IDLE.
REQ-019 MONITOR SHALL respond as follows:
- enable=0 -> IDLE.
- sample & fail -> fault_code |= fvec and strike = 1.
- Next state is ALARM if STRIKE_MAX==1, else SUSPECT.
REQ-020 SUSPECT SHALL respond as follows:
- enable=0 -> IDLE.
- sample & fail -> strike+1 and fault_code |= fvec; when strike+1 == STRIKE_MAX -> ALARM.
- sample & ~fail -> MONITOR, with strike and fault_code cleared.
- sample_hold=1 -> hold all state.
REQ-021 ALARM SHALL assert halt_req=1 and alarm_irq=1 and SHALL remain in ALARM until alarm_ack=1; enable, fail and clear_req SHALL be ignored in ALARM.
REQ-022 On alarm_ack in ALARM:
- alarm_count increments, saturating at 15.
- If the incremented value >= LOCK_MAX -> LOCKOUT, with fault_code retained.
- Otherwise -> MONITOR, with strike and fault_code cleared and alarm_irq deasserted.
REQ-023 alarm_ack SHALL be ignored in every state other than ALARM.
REQ-024 LOCKOUT SHALL respond as follows:
- halt_req=1, alarm_irq=0.
- Exit only on clear_req & supv_ok -> MONITOR; alarm_count, strike and fault_code cleared.
- clear_req with odd-parity secure_supv ignored.
REQ-025 halt_req and alarm_irq SHALL be registered outputs derived from the next state, asserting in the same cycle state shows ALARM or LOCKOUT; latency from the triggering sample edge SHALL be 1 clock.
REQ-026 fault_code SHALL be cleared when MONITOR is entered from SUSPECT, ALARM or LOCKOUT, and SHALL be frozen in ALARM and LOCKOUT.
REQ-027 strike SHALL be a 4-bit internal counter that never exceeds STRIKE_MAX.
REQ-028 alarm_count SHALL change only on ALARM acknowledge (increment) and LOCKOUT clear (to 0); it SHALL NOT wrap.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, strike=0, fault_code=0, alarm_count=0, halt_req=0, alarm_irq=0.
REQ-030 Reset deasserted mid-ALARM or mid-LOCKOUT SHALL restart from IDLE with no residual alarm.

Verification
REQ-031 Sequence: enable=1, then sr_ok=0 for 2 unfrozen samples -> state 1->2->3, halt_req=1, alarm_irq=1, fault_code=3'b100.
REQ-032 Sequence: pipeline_ok=0 for 1 sample, then all healthy -> state 2->1, fault_code=0, halt_req never 1.
REQ-033 Sequence: in SUSPECT, sample_hold=1 for 5 cycles with mmus_ok=0 -> state stays 2, strike unchanged; release -> ALARM next clock.
REQ-034 Sequence: 4 alarms, each acknowledged -> alarm_count=4, state=4, halt_req=1, alarm_irq=0; then clear_req with secure_supv=3'b001 -> no change.
REQ-035 Sequence: in LOCKOUT, clear_req with secure_supv=3'b011 -> state=1, alarm_count=0, fault_code=0, halt_req=0.
REQ-036 Sequence: rst=0 asserted between clock edges while in ALARM -> halt_req=0 immediately (before the next edge), state=0.
